// File: rtl/sensor_pkg.sv
// Shared types and default thresholds for the sensor front end.
// State encodings equal the ST codes so the registered state drives ST directly.
package sensor_pkg;

  localparam logic [1:0] ST_NORMAL = 2'b00;
  localparam logic [1:0] ST_COLD   = 2'b01;
  localparam logic [1:0] ST_HOT    = 2'b11;

  typedef enum logic [1:0] {
    T_NORMAL = ST_NORMAL,
    T_COLD   = ST_COLD,
    T_HOT    = ST_HOT
  } temp_state_e;

  localparam int         DEF_DEBOUNCE_CYCLES = 4;
  localparam logic [7:0] DEF_COLD_ON         = 8'd15;
  localparam logic [7:0] DEF_COLD_OFF        = 8'd18;
  localparam logic [7:0] DEF_HOT_OFF         = 8'd26;
  localparam logic [7:0] DEF_HOT_ON          = 8'd30;
  localparam int         DEF_TEMP_TIMEOUT    = 1000;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a stability counter for one raw contact.
// The output flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module sensor_debounce
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronized input agrees with the output restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/sensor_frontend.sv
// Sensor front end: debounced contacts, hysteretic temperature code with feed
// timeout, and a one-cycle pulse whenever any controller-facing output changes.
module sensor_frontend
  import sensor_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [7:0] COLD_ON         = DEF_COLD_ON,
  parameter logic [7:0] COLD_OFF        = DEF_COLD_OFF,
  parameter logic [7:0] HOT_OFF         = DEF_HOT_OFF,
  parameter logic [7:0] HOT_ON          = DEF_HOT_ON,
  parameter int         TEMP_TIMEOUT    = DEF_TEMP_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sfd_raw,
  input  logic       srd_raw,
  input  logic       sw_raw,
  input  logic       sfa_raw,
  input  logic [7:0] temp_in,
  input  logic       temp_valid,
  output logic       SFD,
  output logic       SRD,
  output logic       SW,
  output logic       SFA,
  output logic [1:0] ST,
  output logic       temp_fault,
  output logic       sensor_changed
);

  if (!(COLD_ON < COLD_OFF && COLD_OFF <= HOT_OFF && HOT_OFF < HOT_ON &&
        DEBOUNCE_CYCLES >= 1 && TEMP_TIMEOUT >= 1)) begin : g_bad_params
    $error("sensor_frontend: illegal threshold or debounce parameters");
  end

  localparam int TW = $clog2(TEMP_TIMEOUT + 1);

  logic [3:0] raw_vec;
  logic [3:0] level_vec;

  assign raw_vec = {sfd_raw, srd_raw, sw_raw, sfa_raw};

  for (genvar gi = 0; gi < 4; gi++) begin : g_contact
    sensor_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (raw_vec[gi]),
      .level_o(level_vec[gi])
    );
  end

  assign {SFD, SRD, SW, SFA} = level_vec;

  temp_state_e   state_q, state_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          fault_q, fault_d;

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    fault_d  = fault_q;
    if (temp_valid) begin
      to_cnt_d = '0;
      fault_d  = 1'b0;
      // While faulted the state is already T_NORMAL, so evaluation starts there.
      unique case (state_q)
        T_NORMAL: begin
          if (temp_in <= COLD_ON)     state_d = T_COLD;
          else if (temp_in >= HOT_ON) state_d = T_HOT;
        end
        T_COLD: begin
          if (temp_in >= HOT_ON)        state_d = T_HOT;
          else if (temp_in >= COLD_OFF) state_d = T_NORMAL;
        end
        T_HOT: begin
          if (temp_in <= COLD_ON)      state_d = T_COLD;
          else if (temp_in <= HOT_OFF) state_d = T_NORMAL;
        end
        default: state_d = T_NORMAL;
      endcase
    end else if (to_cnt_q != TW'(TEMP_TIMEOUT)) begin
      to_cnt_d = to_cnt_q + 1'b1;
      if (to_cnt_q == TW'(TEMP_TIMEOUT - 1)) begin
        fault_d = 1'b1;
        state_d = T_NORMAL;
      end
    end
  end

  logic [5:0] outs_now;
  logic [5:0] outs_prev_q;
  logic       changed_q;

  assign outs_now = {SFD, SRD, SW, SFA, ST};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= T_NORMAL;
      to_cnt_q    <= '0;
      fault_q     <= 1'b0;
      outs_prev_q <= '0;
      changed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      fault_q     <= fault_d;
      outs_prev_q <= outs_now;
      changed_q   <= (outs_now != outs_prev_q);
    end
  end

  assign ST             = state_q;
  assign temp_fault     = fault_q;
  assign sensor_changed = changed_q;

endmodule

// File: tb/tb_sensor_frontend.sv
// Directed bench for sensor_frontend with hand-computed expectations.
module tb_sensor_frontend;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sfd_raw = 1'b0, srd_raw = 1'b0, sw_raw = 1'b0, sfa_raw = 1'b0;
  logic [7:0] temp_in = 8'd0;
  logic       temp_valid = 1'b0;
  logic       SFD, SRD, SW, SFA;
  logic [1:0] ST;
  logic       temp_fault, sensor_changed;

  int checks_q = 0;
  int errors_q = 0;

  always #5 clk = ~clk;

  sensor_frontend dut (
    .clk           (clk),
    .rst           (rst),
    .sfd_raw       (sfd_raw),
    .srd_raw       (srd_raw),
    .sw_raw        (sw_raw),
    .sfa_raw       (sfa_raw),
    .temp_in       (temp_in),
    .temp_valid    (temp_valid),
    .SFD           (SFD),
    .SRD           (SRD),
    .SW            (SW),
    .SFA           (SFA),
    .ST            (ST),
    .temp_fault    (temp_fault),
    .sensor_changed(sensor_changed)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_q++;
    if (act !== exp) begin
      errors_q++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic temp_sample(input logic [7:0] v, input logic [1:0] exp_st, input string tag);
    temp_in    = v;
    temp_valid = 1'b1;
    tick();
    temp_valid = 1'b0;
    check(tag, {30'd0, ST}, {30'd0, exp_st});
    $display("temp %0d -> ST=%b (expect %b)", v, ST, exp_st);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_outs", {26'd0, SFD, SRD, SW, SFA, ST, temp_fault, sensor_changed}, 32'd0);
    rst = 1'b1;
    tick();
    check("rst_release_chg", {31'd0, sensor_changed}, 32'd0);
    tick();
    $display("reset done");

    // Front door debounce: visible on the 6th edge, change pulse on the 7th
    sfd_raw = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("sfd_wait", {31'd0, SFD}, 32'd0);
    end
    tick();
    check("sfd_rise", {31'd0, SFD}, 32'd1);
    check("sfd_chg_early", {31'd0, sensor_changed}, 32'd0);
    tick();
    check("sfd_chg_pulse", {31'd0, sensor_changed}, 32'd1);
    tick();
    check("sfd_chg_once", {31'd0, sensor_changed}, 32'd0);
    $display("sfd debounce SFD=%b", SFD);

    // Short window pulse must be filtered
    sw_raw = 1'b1;
    tick(); tick(); tick();
    sw_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("sw_glitch", {30'd0, SW, sensor_changed}, 32'd0);
    end
    $display("sw glitch SW=%b", SW);

    // Temperature hysteresis
    temp_sample(8'd20, 2'b00, "t20_normal");
    temp_sample(8'd14, 2'b01, "t14_cold");
    temp_sample(8'd16, 2'b01, "t16_hold_cold");
    temp_sample(8'd18, 2'b00, "t18_exit_cold");
    temp_sample(8'd31, 2'b11, "t31_hot");
    temp_sample(8'd27, 2'b11, "t27_hold_hot");
    temp_sample(8'd26, 2'b00, "t26_exit_hot");
    temp_sample(8'd31, 2'b11, "t31_hot_again");
    temp_sample(8'd10, 2'b01, "t10_hot_to_cold");

    // Timeout: fault on the 1000th edge without a strobe
    temp_sample(8'd31, 2'b11, "t31_pre_timeout");
    for (int i = 1; i <= 999; i++) tick();
    check("to_999_fault", {31'd0, temp_fault}, 32'd0);
    check("to_999_st", {30'd0, ST}, 32'd3);
    tick();
    check("to_1000_fault", {31'd0, temp_fault}, 32'd1);
    check("to_1000_st", {30'd0, ST}, 32'd0);
    tick();
    check("to_chg_pulse", {31'd0, sensor_changed}, 32'd1);
    tick(); tick();
    check("to_saturate", {31'd0, temp_fault}, 32'd1);
    check("to_chg_once", {31'd0, sensor_changed}, 32'd0);
    $display("timeout fault=%b ST=%b", temp_fault, ST);
    temp_sample(8'd31, 2'b11, "t31_recover");
    check("to_clear", {31'd0, temp_fault}, 32'd0);

    // Reset mid-debounce with ST=COLD
    temp_sample(8'd10, 2'b01, "t10_cold_pre_rst");
    srd_raw = 1'b1;
    tick(); tick(); tick();
    check("srd_partial", {31'd0, SRD}, 32'd0);
    rst = 1'b0;
    tick();
    check("midrst_outs", {26'd0, SFD, SRD, SW, SFA, ST, temp_fault, sensor_changed}, 32'd0);
    rst = 1'b1;
    tick();
    check("midrst_rel_chg", {31'd0, sensor_changed}, 32'd0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check("srd_restart_wait", {30'd0, SFD, SRD}, 32'd0);
    end
    tick();
    check("srd_restart_rise", {30'd0, SFD, SRD}, 32'd3);
    $display("post-reset SFD=%b SRD=%b", SFD, SRD);

    $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
    $finish;
  end

endmodule
